// File: rtl/rr_mux_8_1.sv
// rr_mux_8_1: 8-to-1 round-robin collecting multiplexer with one registered output stage.
// Merges eight valid/ready producer lanes onto a single stream, tagging each beat with
// the lane index it came from.
//   clk, rst            clock and synchronous active-high reset
//   in_valid[7:0]       per-lane beat present
//   in_data[8*W-1:0]    packed lane data, lane 0 in LSBs
//   in_ready[7:0]       one-hot grant (combinational), zero during reset
//   out_valid           output register holds a beat
//   out_data[W-1:0]     data of the held beat
//   out_sel[2:0]        source lane of the held beat
//   out_ready           consumer accepts the held beat
module rr_mux_8_1 #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     in_valid,
  input  logic [8*W-1:0] in_data,
  output logic [7:0]     in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [2:0]     out_sel,
  input  logic           out_ready
);

  localparam int unsigned LANES = 8;
  localparam int unsigned SEL_W = 3;

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] cand;
  logic             found;
  logic             any_valid;
  logic             load_en;
  logic [W-1:0]     grant_data;

  assign any_valid = |in_valid;
  // Output register can take a new beat when empty or being drained this cycle.
  assign load_en   = !out_valid || out_ready;

  // Round-robin search starting at ptr; 3-bit arithmetic gives the mod-8 wrap.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      cand = ptr + SEL_W'(i);
      if (!found && in_valid[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  assign grant_data = in_data[W*32'(grant) +: W];

  // Grant is only advertised when the beat can actually be captured this edge.
  assign in_ready = (load_en && any_valid && !rst) ? (8'b1 << grant) : 8'b0;

  // Output stage and pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      if (any_valid) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_sel   <= grant;
        ptr       <= grant + SEL_W'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_8_1.sv
module tb_rr_mux_8_1;

  localparam int unsigned W = 8;

  logic           clk;
  logic           rst;
  logic [7:0]     in_valid;
  logic [8*W-1:0] in_data;
  logic [7:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [2:0]     out_sel;
  logic           out_ready;

  int total;
  int passed;

  rr_mux_8_1 #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           rst;
    logic [7:0]     iv;
    logic [8*W-1:0] data;
    logic           ordy;
    logic [7:0]     exp_ir;
    logic           exp_ov;
    logic [W-1:0]   exp_od;
    logic [2:0]     exp_os;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  localparam logic [8*W-1:0] D_ALL  = 64'h1716_1514_1312_1110;
  localparam logic [8*W-1:0] D_L5   = 64'h0000_A500_0000_0000;
  localparam logic [8*W-1:0] D_ZERO = 64'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Drive one cycle of inputs, check the grant before the edge and the outputs after it.
  task automatic step(input string name, input logic r, input logic [7:0] iv,
                      input logic [8*W-1:0] d, input logic ordy, input logic [7:0] exp_ir,
                      input logic exp_ov, input logic [W-1:0] exp_od, input logic [2:0] exp_os);
    rst       = r;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    chk({name, ".in_ready"}, 64'(in_ready), 64'(exp_ir));
    @(posedge clk);
    #1;
    chk({name, ".out_valid"}, 64'(out_valid), 64'(exp_ov));
    chk({name, ".out_data"}, 64'(out_data), 64'(exp_od));
    chk({name, ".out_sel"}, 64'(out_sel), 64'(exp_os));
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst = 1'b1;
    in_valid = 8'hFF;
    in_data = D_ALL;
    out_ready = 1'b1;

    // Reset held two cycles with all lanes requesting
    vecs[0]  = '{1'b1, 8'hFF, D_ALL,  1'b1, 8'h00, 1'b0, 8'h00, 3'd0};
    vecs[1]  = '{1'b1, 8'hFF, D_ALL,  1'b1, 8'h00, 1'b0, 8'h00, 3'd0};
    // Single lane 5
    vecs[2]  = '{1'b0, 8'h20, D_L5,   1'b1, 8'h20, 1'b1, 8'hA5, 3'd5};
    vecs[3]  = '{1'b0, 8'h00, D_ZERO, 1'b1, 8'h00, 1'b0, 8'hA5, 3'd5};
    // Re-reset so the pointer restarts at lane 0
    vecs[4]  = '{1'b1, 8'h00, D_ZERO, 1'b1, 8'h00, 1'b0, 8'h00, 3'd0};
    // All lanes valid: lanes 0..7 in order, back to back
    for (int k = 0; k < 8; k++)
      vecs[5+k] = '{1'b0, 8'hFF, D_ALL, 1'b1, 8'(1 << k), 1'b1, 8'(8'h10 + k), 3'(k)};
    // Backpressure for 3 cycles: nothing granted, output held
    vecs[13] = '{1'b0, 8'hFF, D_ALL,  1'b0, 8'h00, 1'b1, 8'h17, 3'd7};
    vecs[14] = '{1'b0, 8'hFF, D_ALL,  1'b0, 8'h00, 1'b1, 8'h17, 3'd7};
    vecs[15] = '{1'b0, 8'hFF, D_ALL,  1'b0, 8'h00, 1'b1, 8'h17, 3'd7};
    // Release: pointer wrapped to 0, lane 0 loaded on the draining edge
    vecs[16] = '{1'b0, 8'hFF, D_ALL,  1'b1, 8'h01, 1'b1, 8'h10, 3'd0};
    // Idle: output empties, data/sel hold
    vecs[17] = '{1'b0, 8'h00, D_ALL,  1'b1, 8'h00, 1'b0, 8'h10, 3'd0};

    for (int i = 0; i < NV; i++)
      step($sformatf("v%0d", i), vecs[i].rst, vecs[i].iv, vecs[i].data, vecs[i].ordy,
           vecs[i].exp_ir, vecs[i].exp_ov, vecs[i].exp_od, vecs[i].exp_os);

    // Wrap: grant lane 6 to leave ptr=7, then lanes 2 and 6 requesting
    step("wrap_a", 1'b0, 8'h40, D_ALL, 1'b1, 8'h40, 1'b1, 8'h16, 3'd6);
    step("wrap_b", 1'b0, 8'h44, D_ALL, 1'b1, 8'h04, 1'b1, 8'h12, 3'd2);
    step("wrap_c", 1'b0, 8'h44, D_ALL, 1'b1, 8'h40, 1'b1, 8'h16, 3'd6);

    // Reset mid-stream while stalled with a beat held
    step("mrst_a", 1'b1, 8'hFF, D_ALL, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0);
    step("mrst_b", 1'b0, 8'hFF, D_ALL, 1'b1, 8'h01, 1'b1, 8'h10, 3'd0);
    step("mrst_c", 1'b0, 8'hFF, D_ALL, 1'b1, 8'h02, 1'b1, 8'h11, 3'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
